// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and the pixel/colour pipeline.
// oFrameCount is carried only when VGA_TIMING_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CNT_W = 12
);
  logic             iEn;
  logic             oPixelTick;
  logic             oHSync;
  logic             oVSync;
  logic             oVideoOn;
  logic             oLineStart;
  logic             oFrameStart;
  logic [CNT_W-1:0] oPixelX;
  logic [CNT_W-1:0] oPixelY;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0]      oFrameCount;

  modport master (
    input  iEn,
    output oPixelTick, oHSync, oVSync, oVideoOn, oLineStart, oFrameStart,
           oPixelX, oPixelY, oFrameCount
  );
  modport slave (
    output iEn,
    input  oPixelTick, oHSync, oVSync, oVideoOn, oLineStart, oFrameStart,
           oPixelX, oPixelY, oFrameCount
  );
`else
  modport master (
    input  iEn,
    output oPixelTick, oHSync, oVSync, oVideoOn, oLineStart, oFrameStart,
           oPixelX, oPixelY
  );
  modport slave (
    output iEn,
    input  oPixelTick, oHSync, oVSync, oVideoOn, oLineStart, oFrameStart,
           oPixelX, oPixelY
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, H/V counters,
// registered sync/video decode. Optional frame counter: VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12
) (
  input logic               iClk,
  input logic               iRst,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_err_len
    $error("vga_timing_gen: every porch/sync/active length must be non-zero");
  end
  if (CLK_DIV < 1) begin : g_err_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if ((longint'(1) << CNT_W) < longint'(H_TOTAL) ||
      (longint'(1) << CNT_W) < longint'(V_TOTAL)) begin : g_err_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;
  logic             div_last, x_last, y_last, tick;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign x_last   = (x_q == CNT_W'(H_TOTAL - 1));
  assign y_last   = (y_q == CNT_W'(V_TOTAL - 1));
  // Reset wins over enable so no strobe leaks out while iRst is high.
  assign tick     = bus.iEn && !iRst && div_last;

  // Decode is taken from the next-state counters so the registered
  // sync/video bits land on the same edge as the counter they describe.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (bus.iEn) begin
      div_d = div_last ? '0 : div_q + DIV_W'(1);
      if (div_last) begin
        x_d = x_last ? '0 : x_q + CNT_W'(1);
        if (x_last) y_d = y_last ? '0 : y_q + CNT_W'(1);
      end
    end
    hs_d  = ((x_d >= CNT_W'(HS_START)) && (x_d <= CNT_W'(HS_END))) ? HS_POL : ~HS_POL;
    vs_d  = ((y_d >= CNT_W'(VS_START)) && (y_d <= CNT_W'(VS_END))) ? VS_POL : ~VS_POL;
    vid_d = (x_d < CNT_W'(H_ACTIVE)) && (y_d < CNT_W'(V_ACTIVE));
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      vid_q <= 1'b0;
    end else if (bus.iEn) begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vid_q <= vid_d;
    end
  end

  assign bus.oPixelTick  = tick;
  assign bus.oLineStart  = tick && (x_q == '0);
  assign bus.oFrameStart = tick && (x_q == '0) && (y_q == '0);
  assign bus.oHSync      = hs_q;
  assign bus.oVSync      = vs_q;
  assign bus.oVideoOn    = vid_q;
  assign bus.oPixelX     = x_q;
  assign bus.oPixelY     = y_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] fc_q;
  logic        frame_end;

  assign frame_end = bus.iEn && div_last && x_last && y_last;

  always_ff @(posedge iClk) begin
    if (iRst)         fc_q <= '0;
    else if (bus.iEn) fc_q <= fc_q + {15'd0, frame_end};
  end

  assign bus.oFrameCount = fc_q;
`endif

endmodule
